bp_be_ptw_miss_arb: RTL
=======================

# bp_be_ptw_miss_arb

Miss arbiter upstream of the page-table walker. It accepts ITLB and DTLB miss requests and buffers one of each. When the walker is idle it issues exactly one miss packet to the walker, then tracks that walk until a fill or page-fault indication arrives. On completion it returns a per-source done/fault pulse. It handles round-robin arbitration, flush squashing and a walk watchdog.

## Interface
Parameters:
- vaddr_width_p, 39, virtual address width
- timeout_cycles_p, 1024, maximum cycles in eWalk before the watchdog fires; must be at least 4

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- itlb_miss_v_i  in  1  instruction miss request valid
- itlb_miss_vaddr_i  in  vaddr_width_p  faulting fetch address; also used as pc
- itlb_miss_ready_o  out  1  instruction slot can accept
- dtlb_miss_v_i  in  1  data miss request valid
- dtlb_miss_store_i  in  1  1 = store miss, 0 = load miss
- dtlb_miss_vaddr_i  in  vaddr_width_p  data virtual address
- dtlb_miss_pc_i  in  vaddr_width_p  pc of the memory instruction
- dtlb_miss_ready_o  out  1  data slot can accept
- flush_i  in  1  squash pending and in-flight requests
- ptw_busy_i  in  1  walker busy
- ptw_instr_miss_v_o / ptw_load_miss_v_o / ptw_store_miss_v_o  out  1 each  miss packet type; one-hot or all zero
- ptw_vaddr_o, ptw_pc_o  out  vaddr_width_p each  miss packet payload
- ptw_itlb_fill_v_i, ptw_dtlb_fill_v_i  in  1 each  walker fill strobes
- ptw_instr_page_fault_v_i, ptw_load_page_fault_v_i, ptw_store_page_fault_v_i  in  1 each  walker fault strobes
- instr_done_o, data_done_o  out  1 each  one-cycle completion pulse for the matching source
- done_fault_o  out  1  qualifies a done pulse: the walk ended in a page fault
- timeout_o  out  1  one-cycle pulse when the watchdog expires

## Operation
- Slots: one instruction slot and one data slot. Each holds a valid bit, vaddr, pc and a store bit.
- Request acceptance:
  - ready_o = ~slot_v & ~flush_i.
  - v_i & ready_o captures the request and sets slot_v at the next edge.
- Slot in flight: a slot stays valid from capture until its walk completes, times out, or is flushed.
- States and transitions:
  - eIdle: if ~ptw_busy_i and any slot is valid and not already issued, register the grant and go to eIssue.
  - eIssue: drive the miss packet from the granted slot for exactly this one cycle, then go to eWalk. The watchdog clears.
  - eWalk:
    - A completion strobe matching the grant pulses the source's done output, clears that slot and returns to eIdle. Instruction grant matches itlb_fill or instr_fault. Data grant matches dtlb_fill or the load/store fault.
    - done_fault_o = OR of the matching fault strobes.
    - If the watchdog reaches timeout_cycles_p-1 first: pulse timeout_o, clear the slot, return to eIdle with no done pulse.
  - Illegal encodings go to eIdle.
- Arbitration:
  - Only one slot valid: grant it.
  - Both valid: grant the source not granted last (last_grant register, reset = instr, so data wins first).
  - last_grant updates on entry to eIssue.
- Miss packet: ptw_*_miss_v_o are zero outside eIssue. ptw_vaddr_o and ptw_pc_o are zero outside eIssue.
- Flush:
  - flush_i clears both slot_v bits that are not in flight.
  - If a walk is in flight, a squash bit is set. That walk's completion (or timeout) clears the slot silently: no done pulse and no timeout_o.
  - Flush in eIssue: the packet is still sent and the walk is squashed.
- Simultaneous events:
  - Completion and a new request for the same source in one cycle: the request is not accepted (ready_o was low). It is accepted in the following cycle.
  - Completion and flush in one cycle: no done pulse.
- Reset: state = eIdle, slots/squash/last_grant/watchdog cleared, all outputs 0 except ready_o = 1 once reset_n_i is high.

## Timing
- Request accepted at edge N → slot valid in cycle N+1 → eIssue in cycle N+2 (if ptw_busy_i is low in N+1) → walker busy from N+3.
- Done pulse: combinational, in the same cycle as the walker strobe. ready_o rises the next cycle.
- Back-to-back walks: at least 1 eIdle cycle between walks. eIdle waits for ptw_busy_i low, which covers the walker's eWriteBack-to-eIdle cycle.
- Watchdog: counts eWalk cycles, width clog2(timeout_cycles_p), saturating. It never wraps.

## Test plan
- Single load miss: vaddr 0x40_0000_1000, pc 0x8000_0100. Walker raises dtlb_fill 6 cycles after issue. Required: ptw_load_miss_v_o high for exactly 1 cycle; data_done_o=1 and done_fault_o=0 in the fill cycle; dtlb_miss_ready_o=1 on the next cycle.
- Both slots valid in the same cycle, walker completes each in 5 cycles. Required: data issued first, then instr; instr_done_o and data_done_o each pulse exactly once.
- Store miss, walker raises store_page_fault. Required: data_done_o=1 and done_fault_o=1 for 1 cycle, slot cleared.
- flush_i 2 cycles into a data walk, walker fills later. Required: no data_done_o; the slot frees when the fill arrives; the pending instr slot is flushed (instr_ready_o=1).
- timeout_cycles_p=8, walker never completes. Required: timeout_o pulses on the 8th eWalk cycle, no done pulse, state returns to eIdle.
- reset_n_i driven low mid-eWalk. Required: next cycle all outputs 0, both ready_o high after release, and a later walker strobe produces no done pulse.

Source files
------------

// File: rtl/bp_be_ptw_miss_arb.sv
// Miss arbiter in front of the page-table walker: buffers one ITLB and one DTLB miss,
// issues one packet per walk, and reports completion, fault or watchdog expiry per source.
module bp_be_ptw_miss_arb #(
    parameter int vaddr_width_p    = 39,
    parameter int timeout_cycles_p = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     itlb_miss_v_i,
    input  logic [vaddr_width_p-1:0] itlb_miss_vaddr_i,
    output logic                     itlb_miss_ready_o,

    input  logic                     dtlb_miss_v_i,
    input  logic                     dtlb_miss_store_i,
    input  logic [vaddr_width_p-1:0] dtlb_miss_vaddr_i,
    input  logic [vaddr_width_p-1:0] dtlb_miss_pc_i,
    output logic                     dtlb_miss_ready_o,

    input  logic                     flush_i,
    input  logic                     ptw_busy_i,

    output logic                     ptw_instr_miss_v_o,
    output logic                     ptw_load_miss_v_o,
    output logic                     ptw_store_miss_v_o,
    output logic [vaddr_width_p-1:0] ptw_vaddr_o,
    output logic [vaddr_width_p-1:0] ptw_pc_o,

    input  logic                     ptw_itlb_fill_v_i,
    input  logic                     ptw_dtlb_fill_v_i,
    input  logic                     ptw_instr_page_fault_v_i,
    input  logic                     ptw_load_page_fault_v_i,
    input  logic                     ptw_store_page_fault_v_i,

    output logic                     instr_done_o,
    output logic                     data_done_o,
    output logic                     done_fault_o,
    output logic                     timeout_o
);

    localparam int CntW = $clog2(timeout_cycles_p);
    localparam logic [CntW-1:0] CntMax = CntW'(timeout_cycles_p - 1);

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eIssue = 2'd1,
        eWalk  = 2'd2
    } state_e;

    state_e                   r_state;
    logic                     r_islot_v;
    logic [vaddr_width_p-1:0] r_islot_vaddr;
    logic                     r_dslot_v;
    logic                     r_dslot_store;
    logic [vaddr_width_p-1:0] r_dslot_vaddr;
    logic [vaddr_width_p-1:0] r_dslot_pc;
    logic                     r_grant_d;
    logic                     r_last_d;
    logic                     r_squash;
    logic [CntW-1:0]          r_wdog;

    logic w_iready, w_dready;
    logic w_issue, w_walk;
    logic w_iflight, w_dflight;
    logic w_cmpl, w_fault, w_tmo_hit, w_end, w_quiet, w_done;
    logic w_pick_d;

    assign w_iready = reset_n_i & ~r_islot_v & ~flush_i;
    assign w_dready = reset_n_i & ~r_dslot_v & ~flush_i;
    assign itlb_miss_ready_o = w_iready;
    assign dtlb_miss_ready_o = w_dready;

    assign w_issue   = (r_state == eIssue);
    assign w_walk    = (r_state == eWalk);
    assign w_iflight = (r_state != eIdle) & ~r_grant_d;
    assign w_dflight = (r_state != eIdle) &  r_grant_d;

    // Only strobes belonging to the granted source end the walk.
    assign w_cmpl = w_walk & (r_grant_d
                    ? (ptw_dtlb_fill_v_i | ptw_load_page_fault_v_i | ptw_store_page_fault_v_i)
                    : (ptw_itlb_fill_v_i | ptw_instr_page_fault_v_i));
    assign w_fault = r_grant_d ? (ptw_load_page_fault_v_i | ptw_store_page_fault_v_i)
                               : ptw_instr_page_fault_v_i;
    assign w_tmo_hit = w_walk & ~w_cmpl & (r_wdog == CntMax);
    assign w_end     = w_cmpl | w_tmo_hit;

    // A squashed walk, or one ending under flush/reset, retires without any pulse.
    assign w_quiet = r_squash | flush_i | ~reset_n_i;
    assign w_done  = w_cmpl & ~w_quiet;

    assign instr_done_o = w_done & ~r_grant_d;
    assign data_done_o  = w_done &  r_grant_d;
    assign done_fault_o = w_done & w_fault;
    assign timeout_o    = w_tmo_hit & ~w_quiet;

    assign w_pick_d = r_dslot_v & (~r_islot_v | ~r_last_d);

    assign ptw_instr_miss_v_o = w_issue & ~r_grant_d;
    assign ptw_load_miss_v_o  = w_issue &  r_grant_d & ~r_dslot_store;
    assign ptw_store_miss_v_o = w_issue &  r_grant_d &  r_dslot_store;
    assign ptw_vaddr_o = w_issue ? (r_grant_d ? r_dslot_vaddr : r_islot_vaddr) : '0;
    assign ptw_pc_o    = w_issue ? (r_grant_d ? r_dslot_pc    : r_islot_vaddr) : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state       <= eIdle;
            r_islot_v     <= 1'b0;
            r_islot_vaddr <= '0;
            r_dslot_v     <= 1'b0;
            r_dslot_store <= 1'b0;
            r_dslot_vaddr <= '0;
            r_dslot_pc    <= '0;
            r_grant_d     <= 1'b0;
            r_last_d      <= 1'b0;
            r_squash      <= 1'b0;
            r_wdog        <= '0;
        end else begin
            if ((w_end & ~r_grant_d) | (flush_i & ~w_iflight)) begin
                r_islot_v <= 1'b0;
            end else if (itlb_miss_v_i & w_iready) begin
                r_islot_v     <= 1'b1;
                r_islot_vaddr <= itlb_miss_vaddr_i;
            end

            if ((w_end & r_grant_d) | (flush_i & ~w_dflight)) begin
                r_dslot_v <= 1'b0;
            end else if (dtlb_miss_v_i & w_dready) begin
                r_dslot_v     <= 1'b1;
                r_dslot_store <= dtlb_miss_store_i;
                r_dslot_vaddr <= dtlb_miss_vaddr_i;
                r_dslot_pc    <= dtlb_miss_pc_i;
            end

            case (r_state)
                eIdle: begin
                    r_squash <= 1'b0;
                    // Slots being flushed this cycle must not be granted.
                    if (~ptw_busy_i & (r_islot_v | r_dslot_v) & ~flush_i) begin
                        r_grant_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_state   <= eIssue;
                    end
                end
                eIssue: begin
                    r_wdog  <= '0;
                    r_state <= eWalk;
                    if (flush_i) r_squash <= 1'b1;
                end
                eWalk: begin
                    if (w_end) begin
                        r_state  <= eIdle;
                        r_squash <= 1'b0;
                    end else begin
                        if (flush_i) r_squash <= 1'b1;
                        if (r_wdog != CntMax) r_wdog <= r_wdog + CntW'(1);
                    end
                end
                default: r_state <= eIdle;
            endcase
        end
    end

endmodule
